taylor_series: RTL and testbench
================================

# taylor_series

Fixed-point cosine engine that evaluates cos(x) with a 5-term Maclaurin (Taylor) series using one shared multiplier in a small sequential FSM. It takes an unsigned Q2.10 angle in radians, nominally 0 to π/2, and returns an unsigned Q2.10 cosine. It sits as a start/ready coprocessor beside a controller or processor that issues one request at a time.

## Interface
- W, default 12: width of angle_in and cos_out; format Q2.10 (1.0 = 1024).
- FRAC, default 16: fractional bits of the internal accumulator and coefficients.
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset: reset = 0 at a rising edge resets the block.
- start  input  1  request; sampled only in IDLE.
- ready_out  output  1  result-valid level.
- angle_in  input  W  unsigned Q2.10 angle in radians; captured on an accepted start.
- cos_out  output  W  unsigned Q2.10 result.

## Operation
- Series (Horner form): with x2 = x·x, cos = 1 + x2·(−1/2 + x2·(1/24 + x2·(−1/720 + x2·(1/40320)))).
- Coefficients are signed two's-complement Q.FRAC constants. For FRAC = 16: C0 = 65536, C1 = −32768, C2 = 2731, C3 = −91, C4 = 2.
- Angle limit: angle_in > 1608 (π/2) is clamped to 1608 at capture.
- x2 is computed as angle·angle (Q4.20), then shifted right by (20 − FRAC), truncating.
- Each Horner step: acc = Ck + ((x2·acc) >>> FRAC). Signed arithmetic; the product is at least 2·(FRAC+4) bits wide; the shift is arithmetic.
- Output conversion: acc is shifted right by (FRAC − 10) bits, with rounding per Configuration. The result is then saturated to [0, 1024].
- FSM states:
  - IDLE: waits for start.
  - SQR: computes x2; acc ← C4.
  - H3, H2, H1, H0: one Horner step each, adding C3, C2, C1, C0 in that order.
  - OUT: round/saturate, write cos_out.
  - Returns to IDLE.
- Only one multiplier instance is used, time-shared across SQR and H3..H0.
- ready_out:
  - Set when OUT completes.
  - Stays 1 in IDLE.
  - Cleared on the cycle a start is accepted.
- cos_out holds its last result until the next OUT.
- start while not in IDLE is ignored, including start held high across several cycles. start held high when the FSM returns to IDLE begins a new computation.
- Reset, including mid-computation:
  - state → IDLE.
  - ready_out → 0, cos_out → 0.
  - Internal registers → 0.
  - Any in-flight result is discarded.

## Timing
- start = 1 sampled in IDLE at edge N:
  - angle_in is captured at edge N.
  - ready_out = 0 after edge N.
  - SQR at N+1; H3..H0 at N+2..N+5; OUT at N+6.
- After edge N+6: ready_out = 1 and cos_out is valid in the same cycle. Latency is 6 clocks; throughput is one result per 7 clocks.
- ready_out has a rising edge per completed computation. Consumers sample cos_out any time ready_out = 1.
- Reset has priority over start in the same cycle.

## Configuration
- TAYLOR_ROUND_EN defined: round half up at output conversion, i.e. add 2^(FRAC−11) before the shift.
  - Maximum |error| ≤ 1 LSB versus the ideal cos·1024 over 0..1608.
  - Mean error within ±0.5 LSB.
- Undefined: truncate (floor) at output conversion.
  - Error is in [0, +2) LSB, always reading low.
  - Saves one adder.

## Test plan
- Reset held low 2 cycles, then released → ready_out = 0, cos_out = 0; no activity without start.
- angle_in = 0, start one cycle → exactly 6 clocks later ready_out = 1 and cos_out = 1024. angle_in = 1 → 1024.
- angle_in = 512 (0.5 rad) → 899; angle_in = 1024 (1.0 rad) → 553; angle_in = 1608 → 0 or 1; angle_in = 4095 → clamped, same as 1608. All values with TAYLOR_ROUND_EN.
- Sweep angle_in = 1..1608, with start held 2 cycles each and restarted 5 cycles after ready_out rises:
  - every |cos_out − round(cos(angle/1024)·1024)| ≤ 1.
  - mean-square error < 0.5 LSB².
  - exactly one ready_out rise per request.
- start pulsed at N+3 during a computation → ignored. Result at N+6 is for the original angle; ready_out stays 0 until then.
- reset asserted at N+4 mid-computation → ready_out = 0, cos_out = 0, IDLE. A new start then completes normally in 6 clocks.

Source files
------------

// File: rtl/taylor_series.sv
// taylor_series: fixed-point cos(x) coprocessor, 5-term Horner-form Maclaurin
// series evaluated sequentially on one shared signed multiplier.
// Angle in / cosine out are unsigned Q2.10; internal math is signed Q.FRAC.
// Optional build macro: TAYLOR_ROUND_EN (round half up at output conversion;
// when undefined the output is truncated).
module taylor_series #(
   parameter int W    = 12,
   parameter int FRAC = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   output logic         ready_out,
   input  logic [W-1:0] angle_in,
   output logic [W-1:0] cos_out
);

   // Accumulator/x2 width: x2 < 2.47 and |acc| < 2 in Q.FRAC, plus sign and headroom.
   localparam int AW   = FRAC + 6;
   localparam int PW   = 2 * AW;
   // x2 = angle^2 is Q4.20; bring it down to Q.FRAC.
   localparam int SH2  = 20 - FRAC;
   localparam int OSH  = FRAC - 10;
   localparam int ONE  = 1024;
   localparam logic [W-1:0] ANG_MAX = W'(1608);

   // Coefficients 1/k! rounded to nearest in Q.FRAC, alternating signs.
   localparam int C0I = 1 << FRAC;
   localparam int C1I = -(1 << (FRAC - 1));
   localparam int C2I = ((1 << FRAC) + 12) / 24;
   localparam int C3I = -(((1 << FRAC) + 360) / 720);
   localparam int C4I = ((1 << FRAC) + 20160) / 40320;

   localparam logic signed [AW-1:0] C0 = AW'(C0I);
   localparam logic signed [AW-1:0] C1 = AW'(C1I);
   localparam logic signed [AW-1:0] C2 = AW'(C2I);
   localparam logic signed [AW-1:0] C3 = AW'(C3I);
   localparam logic signed [AW-1:0] C4 = AW'(C4I);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SQR  = 3'd1,
      H3   = 3'd2,
      H2   = 3'd3,
      H1   = 3'd4,
      H0   = 3'd5,
      OUT  = 3'd6
   } state_t;

   state_t state_q, state_d;

   logic [W-1:0]           angle;
   logic signed [AW-1:0]   x2;
   logic signed [AW-1:0]   acc;

   logic signed [AW-1:0]   mul_a, mul_b;
   logic signed [PW-1:0]   prod;
   logic signed [AW-1:0]   coef;
   logic signed [AW-1:0]   angle_ext;
   logic signed [AW-1:0]   rnd;
   logic signed [AW-OSH-1:0] out_sh;
   logic [W-1:0]           sat;

   // Parity sink for product/rounding bits that are deliberately dropped.
   logic                   unused_bits;

   assign angle_ext = signed'({{(AW-W){1'b0}}, angle});

   // State register.
   always_ff @(posedge clock) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state: fixed walk IDLE->SQR->H3..H0->OUT->IDLE; start only seen in IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SQR;
         SQR:     state_d = H3;
         H3:      state_d = H2;
         H2:      state_d = H1;
         H1:      state_d = H0;
         H0:      state_d = OUT;
         OUT:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Shared multiplier operand select: angle^2 in SQR, x2*acc in Horner steps.
   always_comb begin
      mul_a = x2;
      mul_b = acc;
      if (state_q == SQR) begin
         mul_a = angle_ext;
         mul_b = angle_ext;
      end
   end

   assign prod = mul_a * mul_b;

   // Coefficient added by each Horner step.
   always_comb begin
      coef = C0;
      case (state_q)
         H3:      coef = C3;
         H2:      coef = C2;
         H1:      coef = C1;
         default: coef = C0;
      endcase
   end

`ifdef TAYLOR_ROUND_EN
   localparam logic signed [AW-1:0] RND = AW'(1 << (FRAC - 11));
   assign rnd = acc + RND;
`else
   assign rnd = acc;
`endif

   assign out_sh = rnd[AW-1:OSH];

   // Clamp the converted result into [0, 1.0].
   always_comb begin
      sat = out_sh[W-1:0];
      if (out_sh < 0)        sat = '0;
      else if (out_sh > ONE) sat = W'(ONE);
   end

   assign unused_bits = ^{prod, rnd};

   // Datapath and handshake registers; reset discards any in-flight work.
   always_ff @(posedge clock) begin
      if (!reset) begin
         angle     <= '0;
         x2        <= '0;
         acc       <= '0;
         cos_out   <= '0;
         ready_out <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  angle     <= (angle_in > ANG_MAX) ? ANG_MAX : angle_in;
                  ready_out <= 1'b0;
               end
            end
            SQR: begin
               x2  <= prod[SH2 +: AW];
               acc <= C4;
            end
            H3, H2, H1, H0: begin
               // Slice at FRAC is the arithmetic shift; the value fits in AW bits.
               acc <= coef + prod[FRAC +: AW];
            end
            OUT: begin
               cos_out   <= sat;
               ready_out <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_taylor_series.sv
// tb_taylor_series: randomized and directed checks of taylor_series against a
// plain-integer evaluation of the fixed-point series and against real cos().
module tb_taylor_series;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [11:0] angle_in = '0;
   logic        ready_out;
   logic [11:0] cos_out;

   int errors = 0;
   int checks = 0;
   int rises = 0;
   int exp_rises = 0;
   logic ready_prev = 1'b0;

   taylor_series #(.W(12), .FRAC(16)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .ready_out (ready_out),
      .angle_in  (angle_in),
      .cos_out   (cos_out)
   );

   always #5 clock = ~clock;

   // Count ready_out rising edges, sampled mid-cycle.
   always @(negedge clock) begin
      if (ready_out && !ready_prev) rises++;
      ready_prev = ready_out;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Fixed-point series: clamp, square to Q.16, Horner with floor shifts, convert.
   function automatic int model(input int a_in);
      longint c [5];
      longint a, x2, acc, r;
      c[0] = 65536; c[1] = -32768; c[2] = 2731; c[3] = -91; c[4] = 2;
      a = (a_in > 1608) ? 1608 : a_in;
      x2 = (a * a) >> 4;
      acc = c[4];
      for (int k = 3; k >= 0; k--) acc = c[k] + ((x2 * acc) >>> 16);
`ifdef TAYLOR_ROUND_EN
      acc = acc + 32;
`endif
      r = acc >>> 6;
      if (r < 0) r = 0;
      if (r > 1024) r = 1024;
      return int'(r);
   endfunction

   task automatic run(input int ang, input int hold, output int res, output int lat);
      @(negedge clock);
      angle_in = ang[11:0];
      start = 1'b1;
      @(posedge clock); #1;
      chk("accept_clears_ready", int'(ready_out), 0);
      lat = 0;
      do begin
         if (lat >= hold - 1) start = 1'b0;
         @(posedge clock); #1;
         lat++;
      end while (!ready_out && lat < 20);
      res = int'(cos_out);
      exp_rises++;
   endtask

   initial begin
      int res, lat, a, d, ideal_i, held;
      real ideal, sum_sq;

      // Reset held two cycles, then idle with no start.
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("reset_ready", int'(ready_out), 0);
      chk("reset_cos", int'(cos_out), 0);
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("idle_ready", int'(ready_out), 0);
      chk("idle_cos", int'(cos_out), 0);

      // Directed angles.
      run(0, 1, res, lat);
      chk("a0_lat", lat, 6);
      chk("a0_val", res, 1024);
      run(1, 1, res, lat);
      chk("a1_lat", lat, 6);
      chk("a1_val", res, 1024);
      run(512, 1, res, lat);
      chk("a512_model", res, model(512));
`ifdef TAYLOR_ROUND_EN
      chk("a512_val", res, 899);
`endif
      run(1024, 1, res, lat);
      chk("a1024_model", res, model(1024));
`ifdef TAYLOR_ROUND_EN
      chk("a1024_val", res, 553);
      run(1608, 1, res, lat);
      chk("a1608_le1", int'(res <= 1), 1);
`else
      run(1608, 1, res, lat);
`endif
      chk("a1608_model", res, model(1608));
      run(4095, 1, res, lat);
      chk("a4095_clamp", res, model(1608));

      // Result and ready hold while idle.
      held = res;
      repeat (4) @(posedge clock);
      #1;
      chk("hold_ready", int'(ready_out), 1);
      chk("hold_cos", int'(cos_out), held);

      // Random angles over the full input range.
      for (int i = 0; i < 24; i++) begin
         a = int'($urandom_range(0, 4095));
         run(a, 1 + int'($urandom_range(0, 1)), res, lat);
         chk("rand_lat", lat, 6);
         chk("rand_val", res, model(a));
      end

      // start pulsed mid-computation is ignored.
      @(negedge clock);
      angle_in = 12'd300;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      angle_in = 12'd1000;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      chk("midstart_ready", int'(ready_out), 0);
      lat = 3;
      while (!ready_out && lat < 20) begin
         @(posedge clock); #1;
         lat++;
      end
      exp_rises++;
      chk("midstart_lat", lat, 6);
      chk("midstart_val", int'(cos_out), model(300));
      repeat (3) @(posedge clock);
      #1;
      chk("midstart_no_restart", int'(ready_out), 1);

      // Reset mid-computation discards the result.
      @(negedge clock);
      angle_in = 12'd700;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      @(posedge clock); #1;
      chk("midreset_ready", int'(ready_out), 0);
      chk("midreset_cos", int'(cos_out), 0);
      reset = 1'b1;
      repeat (8) @(posedge clock);
      #1;
      chk("midreset_idle_ready", int'(ready_out), 0);
      run(200, 1, res, lat);
      chk("after_reset_lat", lat, 6);
      chk("after_reset_val", res, model(200));

      // Full sweep, start held two cycles, restart 5 cycles after completion.
      sum_sq = 0.0;
      for (int s = 1; s <= 1608; s++) begin
         run(s, 2, res, lat);
         chk("sweep_lat", lat, 6);
         chk("sweep_model", res, model(s));
         ideal = $cos(real'(s) / 1024.0) * 1024.0;
         ideal_i = int'(ideal);
         d = res - ideal_i;
         sum_sq = sum_sq + (real'(res) - ideal) * (real'(res) - ideal);
`ifdef TAYLOR_ROUND_EN
         chk("sweep_err1", int'(d >= -1 && d <= 1), 1);
`else
         chk("sweep_err2", int'(d >= -2 && d <= 1), 1);
`endif
         repeat (5) @(posedge clock);
      end
`ifdef TAYLOR_ROUND_EN
      chk("sweep_mse", int'(sum_sq / 1608.0 < 0.5), 1);
`endif

      @(posedge clock); #1;
      @(negedge clock);
      chk("ready_rises", rises, exp_rises);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
